// File: rtl/prio_encoder_8to3_hs_if.sv
// Request/acknowledge bus for the 8-to-3 priority encoder.
// The slave modport is the encoder side and the master modport is the
// collector/consumer side.
//
// Handshake: the encoder raises valid with a stable index on y. The consumer
// answers with ack, which is sampled on a rising clk edge. One valid cycle
// that sees ack = 1 completes the transfer. ack while valid = 0 has no effect.
interface prio_encoder_8to3_hs_if;
    logic [7:0] x_n;        // active-low request lines, asynchronous to clk
    logic [2:0] g;          // enable triple, enabled when 3'b100
    logic       ack;        // consumer acknowledge
    logic [2:0] y;          // presented index
    logic       valid;      // y holds a presented request
    logic       gs_n;       // active low: some pending bit is set
    logic [7:0] pend;       // pending-event register (debug)
    logic       fsm_state;  // current FSM state (debug)

    modport slave (
        input  x_n,
        input  g,
        input  ack,
        output y,
        output valid,
        output gs_n,
        output pend,
        output fsm_state
    );

    modport master (
        output x_n,
        output g,
        output ack,
        input  y,
        input  valid,
        input  gs_n,
        input  pend,
        input  fsm_state
    );
endinterface

// File: rtl/prio_encoder_8to3_hs.sv
// Registered 8-to-3 priority encoder with enable gating and a req/ack
// handshake. Falling edges on the synchronized x_n lines are latched as
// pending events. The highest-priority pending index is presented on y
// and held until it is acknowledged.
module prio_encoder_8to3_hs #(
    parameter int SYNC_STAGES    = 2,    // legal 1..3
    parameter bit LOW_PRIO_FIRST = 1'b0  // 0: index 7 wins, 1: index 0 wins
) (
    input  logic                   clk,
    input  logic                   rst,
    prio_encoder_8to3_hs_if.slave  bus
);

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_PRESENT = 1'b1;

    logic [7:0] sync_q [SYNC_STAGES];
    logic [7:0] s_n;
    logic [7:0] h_n_q;
    logic [7:0] fall;
    logic       enabled;

    logic [0:0] state_q, state_d;
    logic [2:0] y_q, y_d;
    logic [7:0] pend_q, pend_d;
    logic       gs_n_q;
    logic [7:0] clr_mask;
    logic [2:0] sel_idx;

    // Returns the winning index among the set bits of p.
    // When p is zero the result is 0 and is not used.
    function automatic logic [2:0] pick(input logic [7:0] p);
        logic [2:0] idx;
        idx = 3'd0;
        if (LOW_PRIO_FIRST) begin
            for (int i = 7; i >= 0; i--) begin
                if (p[i]) idx = 3'(i);
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (p[i]) idx = 3'(i);
            end
        end
        return idx;
    endfunction

    // Synchronizer chain. It resets idle-high so that reset itself creates no events.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= 8'hFF;
        end else begin
            sync_q[0] <= bus.x_n;
            for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
        end
    end

    assign s_n = sync_q[SYNC_STAGES-1];

    // Edge history. It tracks s_n even while the block is disabled, so a line that is
    // already low on re-enable does not produce an event.
    always_ff @(posedge clk) begin
        if (rst) h_n_q <= 8'hFF;
        else     h_n_q <= s_n;
    end

    assign fall    = h_n_q & ~s_n;
    assign enabled = (bus.g == 3'b100);
    assign sel_idx = pick(pend_q);

    // Handshake FSM and pending update. A set from a new event wins over the
    // clear from an ack on the same bit.
    always_comb begin
        state_d  = state_q;
        y_d      = y_q;
        clr_mask = 8'h00;
        case (state_q)
            ST_IDLE: begin
                if (enabled && (pend_q != 8'h00)) begin
                    y_d     = sel_idx;
                    state_d = ST_PRESENT;
                end
            end
            ST_PRESENT: begin
                if (bus.ack) begin
                    clr_mask = 8'h01 << y_q;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        pend_d = (pend_q & ~clr_mask) | (enabled ? fall : 8'h00);
    end

    // State, presented code, pending register and its summary flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            y_q     <= 3'd0;
            pend_q  <= 8'h00;
            gs_n_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            pend_q  <= pend_d;
            gs_n_q  <= ~|pend_d;
        end
    end

    assign bus.y         = y_q;
    assign bus.valid     = (state_q == ST_PRESENT);
    assign bus.gs_n      = gs_n_q;
    assign bus.pend      = pend_q;
    assign bus.fsm_state = state_q;

endmodule

// File: doc/prio_encoder_8to3_hs.md
Name: prio_encoder_8to3_hs

Overview:
- Registered 8-to-3 priority encoder with enable gating and a request/acknowledge handshake. It is the inverse of the team's 3-to-8 active-low decoder with enable.
- Accepts eight active-low request lines, latches each new assertion as a pending event, and presents the highest-priority pending index as a 3-bit code.
- The code is held stable until the consumer acknowledges it. Typical use: interrupt/request collection in front of the lab datapath.

Parameters:
- SYNC_STAGES, 2, synchronizer flip-flop stages on x_n; legal 1..3.
- LOW_PRIO_FIRST, 0, 0 = index 7 wins; 1 = index 0 wins.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active high
- x_n  input  8  request lines, active low, asynchronous to clk
- g  input  3  enable triple; block enabled only when g == 3'b100 (g[2] high, g[1:0] low)
- ack  input  1  consumer acknowledge, sampled at clk edge
- y  output  3  encoded index of the presented request
- valid  output  1  y holds a presented request
- gs_n  output  1  active low; 0 when any pending bit is set
- pend  output  8  pending-event register, for debug/visibility

Behaviour:
- Reset (rst = 1 at a clk edge):
  - y = 3'b000, valid = 0, gs_n = 1, pend = 8'h00.
  - Synchronizer stages and edge-history register set to 8'hFF (idle-high).
  - FSM goes to IDLE.
  - Reset mid-handshake drops the presented request and all pending events without an ack.
- Input path:
  - x_n passes through SYNC_STAGES flops, giving s_n.
  - A history register h_n holds the previous s_n.
  - Assertion event on bit i: h_n[i] = 1 and s_n[i] = 0 (falling edge).
  - A line held low produces exactly one event.
- Pending capture:
  - Only while enabled (g == 3'b100): pend[i] is set on an event for bit i.
  - While disabled, events are discarded, but h_n still tracks s_n, so a line already low on re-enable produces no event.
  - Existing pend bits are retained while disabled.
- Priority select, combinational from pend:
  - LOW_PRIO_FIRST = 0: highest set index wins.
  - LOW_PRIO_FIRST = 1: lowest set index wins.
- FSM states: IDLE and PRESENT.
  - IDLE, enabled and pend != 0: load y = selected index, valid = 1, go to PRESENT. Latency: event edge to valid = SYNC_STAGES + 2 clk.
  - IDLE, disabled: remain in IDLE with valid = 0.
  - PRESENT: y and valid hold stable regardless of new events, higher-priority arrivals, or g changes.
  - PRESENT with ack = 1: clear pend[y], set valid = 0, return to IDLE. The next selection follows at the earliest one cycle later, so there is one idle bubble between presentations.
  - ack while IDLE is ignored.
- Simultaneous events:
  - An event on the same bit as the bit being acked in the same cycle re-sets pend[y]; set wins over clear.
  - Multiple events in one cycle all set their pend bits.
- gs_n = ~|pend, registered alongside pend. It is independent of g.
- Re-trigger: a line must return high and fall again (after sync) to create a new event. A pulse shorter than one clk may be missed; this is permitted.

Test Plan:
- Reset applied, g = 100, all x_n = FF -> y = 0, valid = 0, gs_n = 1, pend = 00; hold 10 cycles, no change.
- g = 100, x_n[5] falls, SYNC_STAGES = 2 -> pend = 20 and valid = 1 with y = 5 exactly 4 clk after the edge; ack 1 cycle -> valid = 0, pend = 00, gs_n = 1; x_n[5] held low -> no re-trigger.
- x_n[2] and x_n[6] fall in the same cycle, LOW_PRIO_FIRST = 0 -> y = 6 first; ack -> one bubble cycle, then y = 2; ack -> pend = 00. Repeat with LOW_PRIO_FIRST = 1 -> order 2 then 6.
- While y = 3 is presented, x_n[7] falls -> y stays 3 until ack; then y = 7.
- g = 000, x_n[1] falls -> pend stays 00 and valid stays 0; set g = 100 with x_n[1] still low -> no event; release x_n[1], drop it again -> y = 1.
- Ack of y = 4 coincides with a fresh event on bit 4 -> pend[4] stays 1 and y = 4 is re-presented after the bubble; rst asserted while valid = 1 -> all outputs return to reset values on the next clk.
